// File: rtl/mem_access_unit_if.sv
// Word-aligned req/ack memory bus between the M-stage access unit (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: one bus transaction per instruction, stalls the pipeline until it
// completes, and returns extended load data for W.
module mem_access_unit #(
  parameter int          AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memreadM,
  input  logic [1:0]               memwriteM,
  input  logic [2:0]               readtypeM,
  input  logic [AW-1:0]            addrM,
  input  logic [31:0]              wdataM,
  output logic [31:0]              readdataM,
  output logic                     stallM,
  output logic                     misalignM,
  output logic                     buserrM,
  mem_access_unit_if.master        bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    lo_q, lo_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [2:0]    type_q, type_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic is_wr, access, sz_byte, sz_half, aligned, start;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A store takes priority over a simultaneous load, so its size governs alignment.
  always_comb begin
    is_wr   = (memwriteM != 2'b00);
    access  = memreadM | is_wr;
    sz_byte = is_wr ? (memwriteM == 2'b10)
                    : (readtypeM == 3'b001 || readtypeM == 3'b010);
    sz_half = is_wr ? (memwriteM == 2'b11)
                    : (readtypeM == 3'b011 || readtypeM == 3'b100);
    aligned = sz_byte | (sz_half & ~addrM[0]) | (~sz_byte & ~sz_half & (addrM[1:0] == 2'b00));
    start   = (state_q == IDLE) & access & aligned;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    type_d  = type_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          addr_d  = {addrM[AW-1:2], 2'b00};
          lo_d    = addrM[1:0];
          we_d    = is_wr;
          type_d  = readtypeM;
          cnt_d   = '0;
          if (!is_wr || memwriteM == 2'b01) begin
            be_d    = 4'b1111;
            wdata_d = wdataM;
          end else if (memwriteM == 2'b10) begin
            be_d    = 4'b0001 << addrM[1:0];
            wdata_d = {4{wdataM[7:0]}};
          end else begin
            be_d    = addrM[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdataM[15:0]}};
          end
        end
      end
      BUSY: begin
        // An ack arriving on the last allowed cycle still counts as success.
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      type_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      type_q  <= type_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    byte_sel = rdata_q[{lo_q, 3'b000} +: 8];
    half_sel = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (type_q)
      3'b001:  readdataM = {24'b0, byte_sel};
      3'b010:  readdataM = {{24{byte_sel[7]}}, byte_sel};
      3'b011:  readdataM = {16'b0, half_sel};
      3'b100:  readdataM = {{16{half_sel[15]}}, half_sel};
      default: readdataM = rdata_q;
    endcase
  end

  // IDLE-time combinational outputs are masked while reset is held.
  assign stallM    = (state_q == BUSY) | (start & reset);
  assign misalignM = (state_q == IDLE) & access & ~aligned & reset;
  assign buserrM   = (state_q == DONE) & err_q;

  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized loads/stores against a byte-level model.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memreadM = 1'b0;
  logic [1:0]  memwriteM = 2'b00;
  logic [2:0]  readtypeM = 3'b000;
  logic [31:0] addrM = '0;
  logic [31:0] wdataM = '0;
  logic [31:0] readdataM;
  logic        stallM, misalignM, buserrM;

  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;

  mem_access_unit_if #(.AW(32)) bus_if ();

  always #5 clk = ~clk;

  mem_access_unit #(.AW(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .readtypeM (readtypeM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .readdataM (readdataM),
    .stallM    (stallM),
    .misalignM (misalignM),
    .buserrM   (buserrM),
    .bus       (bus_if)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, byte lanes and load extension from plain arithmetic.
  function automatic int acc_bytes(input logic [1:0] wr, input logic [2:0] rt);
    if (wr == 2'd1) return 4;
    if (wr == 2'd2) return 1;
    if (wr == 2'd3) return 2;
    if (rt == 3'd1 || rt == 3'd2) return 1;
    if (rt == 3'd3 || rt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] rt, input int off, input logic [31:0] rdata);
    int n;
    longint mask, val;
    n    = acc_bytes(2'd0, rt);
    mask = (longint'(1) << (8 * n)) - 1;
    val  = (longint'(rdata) >> (8 * off)) & mask;
    if ((rt == 3'd2 || rt == 3'd4) && val >= (longint'(1) << (8 * n - 1)))
      val = val - (longint'(1) << (8 * n));
    return val[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
    if (n == 1) return {24'b0, wd[7:0]} * 32'h01010101;
    if (n == 2) return {16'b0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  task automatic clear_inputs();
    memreadM  = 1'b0;
    memwriteM = 2'b00;
    readtypeM = 3'b000;
    addrM     = '0;
    wdataM    = '0;
  endtask

  // ack_dly: BUSY cycle index on which mem_ack is pulsed; >= TMO means never.
  task automatic do_access(input logic rd, input logic [1:0] wr, input logic [2:0] rt,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rdata);
    int n, off, k, stalls, exp_stalls;
    logic aligned, is_wr, err, done;
    logic [31:0] exp_be, exp_rd;
    n       = acc_bytes(wr, rd ? rt : 3'd0);
    if (wr == 2'd0) n = acc_bytes(2'd0, rt);
    off     = int'(addr[1:0]);
    aligned = (off % n) == 0;
    is_wr   = (wr != 2'd0);
    exp_be  = is_wr ? (((32'd1 << n) - 1) << off) : 32'hF;
    n_txn++;

    @(negedge clk);
    memreadM = rd; memwriteM = wr; readtypeM = rt; addrM = addr; wdataM = wd;
    #1;
    check_val("stall_idle", 32'(stallM), 32'(aligned));
    check_val("misalign", 32'(misalignM), 32'(!aligned));
    check_val("req_idle", 32'(bus_if.mem_req), 32'd0);
    if (!aligned) begin
      @(posedge clk);
      #1 clear_inputs();
      @(negedge clk);
      check_val("misalign_pulse", 32'(misalignM), 32'd0);
      check_val("req_after_misalign", 32'(bus_if.mem_req), 32'd0);
      check_val("stall_after_misalign", 32'(stallM), 32'd0);
      $display("txn %0d rd=%0b wr=%0d rt=%0d addr=%08h misaligned", n_txn, rd, wr, rt, addr);
      return;
    end
    @(posedge clk);
    #1 clear_inputs();

    stalls = 1;
    k      = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      check_val("busy_req", 32'(bus_if.mem_req), 32'd1);
      check_val("busy_we", 32'(bus_if.mem_we), 32'(is_wr));
      check_val("busy_addr", bus_if.mem_addr, {addr[31:2], 2'b00});
      check_val("busy_be", 32'(bus_if.mem_be), exp_be);
      if (is_wr) check_val("busy_wdata", bus_if.mem_wdata, model_wdata(n, wd));
      if (stallM) stalls++;
      if (k == ack_dly) begin
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = rdata;
      end else begin
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = $urandom;
      end
      @(posedge clk);
      #1 bus_if.mem_ack = 1'b0;
      if (k == ack_dly || k == TMO - 1) done = 1'b1;
      k++;
    end

    err        = (ack_dly >= TMO);
    exp_stalls = 1 + (err ? TMO : ack_dly + 1);
    exp_rd     = err ? 32'd0 : model_load(rt, off, rdata);
    @(negedge clk);
    check_val("done_stall", 32'(stallM), 32'd0);
    check_val("done_req", 32'(bus_if.mem_req), 32'd0);
    check_val("done_buserr", 32'(buserrM), 32'(err));
    check_val("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (!is_wr) check_val("readdata", readdataM, exp_rd);
    $display("txn %0d rd=%0b wr=%0d rt=%0d addr=%08h ack_dly=%0d readdata=%08h buserr=%0b",
             n_txn, rd, wr, rt, addr, ack_dly, readdataM, buserrM);
  endtask

  initial begin
    logic [31:0] r_addr, r_wd, r_rd;
    int kind;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_val("rst_stall", 32'(stallM), 32'd0);
    check_val("rst_misalign", 32'(misalignM), 32'd0);
    check_val("rst_buserr", 32'(buserrM), 32'd0);
    check_val("rst_req", 32'(bus_if.mem_req), 32'd0);
    check_val("rst_we", 32'(bus_if.mem_we), 32'd0);
    check_val("rst_addr", bus_if.mem_addr, 32'd0);
    check_val("rst_be", 32'(bus_if.mem_be), 32'd0);
    check_val("rst_wdata", bus_if.mem_wdata, 32'd0);
    check_val("rst_readdata", readdataM, 32'd0);
    reset = 1'b1;

    do_access(1'b1, 2'd0, 3'd0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check_val("lw_value", readdataM, 32'hDEADBEEF);
    do_access(1'b1, 2'd0, 3'd2, 32'h103, 32'h0, 1, 32'h80112233);
    check_val("lb_value", readdataM, 32'hFFFFFF80);
    do_access(1'b1, 2'd0, 3'd1, 32'h103, 32'h0, 0, 32'h80112233);
    check_val("lbu_value", readdataM, 32'h00000080);
    do_access(1'b1, 2'd0, 3'd4, 32'h102, 32'h0, 2, 32'h80112233);
    check_val("lh_value", readdataM, 32'hFFFF8011);
    do_access(1'b0, 2'd2, 3'd0, 32'h101, 32'h000000A5, 0, 32'h0);
    do_access(1'b0, 2'd3, 3'd0, 32'h102, 32'h00001234, 1, 32'h0);
    do_access(1'b1, 2'd0, 3'd0, 32'h102, 32'h0, 0, 32'h0);
    do_access(1'b0, 2'd3, 3'd0, 32'h101, 32'h0, 0, 32'h0);
    do_access(1'b1, 2'd0, 3'd0, 32'h104, 32'h0, 99, 32'h12345678);
    do_access(1'b1, 2'd0, 3'd0, 32'h108, 32'h0, 3, 32'hCAFEF00D);
    do_access(1'b1, 2'd1, 3'd0, 32'h10C, 32'h55AA55AA, 0, 32'h0);

    // Reset while BUSY, with an ack still pending across the release.
    @(negedge clk);
    memreadM = 1'b1; addrM = 32'h200;
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    check_val("pre_reset_req", 32'(bus_if.mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("async_req", 32'(bus_if.mem_req), 32'd0);
    check_val("async_stall", 32'(stallM), 32'd0);
    check_val("async_addr", bus_if.mem_addr, 32'd0);
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 bus_if.mem_ack = 1'b0;
    @(negedge clk);
    check_val("ack_after_reset_req", 32'(bus_if.mem_req), 32'd0);
    check_val("ack_after_reset_stall", 32'(stallM), 32'd0);
    check_val("ack_after_reset_rd", readdataM, 32'd0);
    $display("txn reset during BUSY, ack after release");
    do_access(1'b1, 2'd0, 3'd0, 32'h300, 32'h0, 1, 32'h0BADF00D);

    for (int i = 0; i < 40; i++) begin
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      kind   = $urandom_range(0, 3);
      r_addr[31:12] = '0;
      case (kind)
        0, 1:    do_access(1'b1, 2'd0, 3'($urandom_range(0, 7)), r_addr, r_wd,
                           $urandom_range(0, 5), r_rd);
        2:       do_access(1'b0, 2'($urandom_range(1, 3)), 3'd0, r_addr, r_wd,
                           $urandom_range(0, 5), r_rd);
        default: do_access(1'b1, 2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), r_addr, r_wd,
                           $urandom_range(0, 5), r_rd);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
